// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 pad signals between a host-side driver and the transmitter.
//   wr_ps2/din       : write strobe and command byte (driver -> transmitter)
//   ps2c_in/ps2d_in  : PS/2 clock/data pad levels (pad -> transmitter)
//   ps2c_oe/ps2d_oe  : open-drain pull-low enables (transmitter -> pad)
//   tx_idle, tx_done_tick, tx_err_tick : status back to the driver
interface ps2_host_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;
  modport master (
    output wr_ps2, din, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick
  );
  modport slave (
    input  wr_ps2, din, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte with odd parity and ack check.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : ps2_host_tx_if.slave (write strobe/byte in, pad levels in, pad pull-low enables and status out)
module ps2_host_tx #(
  parameter int RTS_CYCLES     = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILT_LEN       = 8
) (
  input logic          clk,
  input logic          reset,
  ps2_host_tx_if.slave bus
);
  localparam int MAXC = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(FILT_LEN + 1);
  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    c_sync_q, d_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          flip, fall;
  logic [8:0]    pkt_q, pkt_d;
  logic [3:0]    n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, err_q, err_d;
  logic          wd, timeout;
  // Filtered clock flips on the FILT_LEN-th consecutive sample that disagrees with it.
  assign flip   = (c_sync_q[1] != filt_q) && (fcnt_q == FW'(FILT_LEN - 1));
  assign filt_d = flip ? c_sync_q[1] : filt_q;
  assign fcnt_d = (flip || c_sync_q[1] == filt_q) ? '0 : fcnt_q + 1'b1;
  assign fall   = flip & filt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      c_sync_q <= {c_sync_q[0], bus.ps2c_in};
      d_sync_q <= {d_sync_q[0], bus.ps2d_in};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wd      = state_q inside {START, DATA, STOP, ACK};
    timeout = wd && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    case (state_q)
      IDLE: if (bus.wr_ps2) begin
        state_d = RTS;
        pkt_d   = {~^bus.din, bus.din};
        cnt_d   = '0;
      end
      RTS: begin
        cnt_d   = (cnt_q == CW'(RTS_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(RTS_CYCLES - 1)) ? START : RTS;
      end
      START: if (fall) begin
        state_d = DATA;
        n_d     = '0;
      end
      DATA: if (fall) begin
        pkt_d   = pkt_q >> 1;
        n_d     = n_q + 1'b1;
        state_d = (n_q == 4'd8) ? STOP : DATA;
      end
      STOP: state_d = fall ? ACK : STOP;
      ACK: if (fall) begin
        state_d = IDLE;
        done_d  = ~d_sync_q[1];
        err_d   = d_sync_q[1];
      end
      default: state_d = IDLE;
    endcase
    if (wd) cnt_d = cnt_q + 1'b1;
    // Watchdog expiry overrides any simultaneous clock edge.
    if (timeout) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end
  always_comb begin
    bus.tx_idle      = state_q == IDLE;
    bus.ps2c_oe      = state_q == RTS;
    bus.ps2d_oe      = (state_q == START) || (state_q == DATA && !pkt_q[0]);
    bus.tx_done_tick = done_q;
    bus.tx_err_tick  = err_q;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx.
module tb_ps2_host_tx;
  localparam int RTS  = 1200;
  localparam int TO   = 4000;
  localparam int FILT = 8;
  localparam int HALF = 40;
  typedef struct {
    bit         done;
    bit         chk;
    logic [9:0] bits;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic [9:0] rx_bits = '0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       me;
  ps2_host_tx_if bus();
  ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO), .FILT_LEN(FILT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.ps2c_in = dev_c & ~bus.ps2c_oe;
  assign bus.ps2d_in = dev_d & ~bus.ps2d_oe;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.tx_done_tick === 1'b1 || bus.tx_err_tick === 1'b1) begin
      if (q.size() == 0) chk("unexpected_tick", 1, 0);
      else begin
        me = q.pop_front();
        chk("tick_kind", {bus.tx_done_tick, bus.tx_err_tick}, me.done ? 2'b10 : 2'b01);
        chk("idle_at_tick", bus.tx_idle, 1);
        if (me.chk) chk("frame_bits", rx_bits, me.bits);
      end
    end
  end
  task automatic device(input string tag, input int nclk, input bit ack, input bit glitch);
    int t;
    t = 0;
    rx_bits = '0;
    while (!(bus.ps2d_oe && !bus.ps2c_oe) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start_seen"}, t < 20000, 1);
    repeat (20) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) dev_d = 1'b0;
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      if (glitch && k <= 9) begin
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF - 14) @(negedge clk);
      end else repeat (HALF - 1) @(negedge clk);
      if (k <= 10) rx_bits[k-1] = bus.ps2d_in;
      @(negedge clk);
    end
    dev_d = 1'b1;
  endtask
  // mode: 0 ack, 1 no ack, 2 device stalls, 3 glitches, 4 overlapping write, 5 stop mid-data
  task automatic send(input logic [7:0] b, input logic [9:0] frame, input int mode, input string tag);
    int n;
    int t;
    exp_t e;
    if (mode != 5) begin
      e.done = (mode == 0 || mode == 3 || mode == 4);
      e.chk  = (mode != 2);
      e.bits = frame;
      q.push_back(e);
    end
    @(negedge clk);
    bus.din    = b;
    bus.wr_ps2 = 1'b1;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    chk({tag, "_idle_fall"}, bus.tx_idle, 0);
    chk({tag, "_rts_oe"}, {bus.ps2c_oe, bus.ps2d_oe}, 2'b10);
    n = 0;
    while (bus.ps2c_oe && n < RTS + 100) begin
      n++;
      if (mode == 4 && n == 100) begin
        bus.din    = 8'h55;
        bus.wr_ps2 = 1'b1;
      end else bus.wr_ps2 = 1'b0;
      @(negedge clk);
    end
    bus.wr_ps2 = 1'b0;
    chk({tag, "_rts_len"}, n, RTS);
    case (mode)
      1:       device(tag, 12, 1'b0, 1'b0);
      2:       device(tag, 3, 1'b0, 1'b0);
      3:       device(tag, 12, 1'b1, 1'b1);
      5:       device(tag, 2, 1'b0, 1'b0);
      default: device(tag, 12, 1'b1, 1'b0);
    endcase
    if (mode != 5) begin
      t = 0;
      while (!bus.tx_idle && t < TO + 200) begin
        @(negedge clk);
        t++;
      end
      chk({tag, "_idle_end"}, bus.tx_idle, 1);
      chk({tag, "_released"}, {bus.ps2c_oe, bus.ps2d_oe}, 2'b00);
      if (mode == 2) chk({tag, "_wd_delay"}, (t >= TO - 300) && (t <= TO - 220), 1);
    end
  endtask
  initial begin
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    #1 reset = 1'b0;
    #1;
    chk("rst_idle", bus.tx_idle, 1);
    chk("rst_oe", {bus.ps2c_oe, bus.ps2d_oe}, 2'b00);
    chk("rst_ticks", {bus.tx_done_tick, bus.tx_err_tick}, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    send(8'hED, 10'b11_1110_1101, 0, "ed");
    send(8'h07, 10'b10_0000_0111, 0, "p07");
    send(8'hFF, 10'b11_1111_1111, 0, "pff");
    send(8'hED, 10'b11_1110_1101, 4, "ovl");
    send(8'hED, 10'b11_1110_1101, 1, "noack");
    send(8'hED, 10'b11_1110_1101, 2, "stall");
    send(8'hED, 10'b11_1110_1101, 5, "mid");
    chk("mid_busy", {bus.tx_idle, bus.ps2d_oe}, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_idle", bus.tx_idle, 1);
    chk("mid_rst_oe", {bus.ps2c_oe, bus.ps2d_oe}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    send(8'hED, 10'b11_1110_1101, 3, "glitch");
    repeat (50) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
